hv_pwm_intb_encode_mch: RTL and testbench
=========================================

HV_PWM_INTB_ENCODE_MCH -- requirements
Module: hv_pwm_intb_encode_mch

Interface
REQ-001 SHALL provide parameter CH_NUM, default 2, number of independent PWM/INTB channels (1..8).
REQ-002 SHALL provide parameter EXT_CYC_NUM, default 4, clock cycles each encoded bit is held (>=2).
REQ-003 SHALL provide parameter WDG_CNT_W, default 16, watchdog counter width.
REQ-004 SHALL provide port i_clk  input  1  the single block clock; all logic is on its rising edge.
REQ-005 SHALL provide port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port i_hv_intb_n  input  CH_NUM  per-channel interrupt level, active low.
REQ-007 SHALL provide port i_hv_pwm_gwave  input  CH_NUM  per-channel PWM gate wave.
REQ-008 SHALL provide port i_wdgintb_en  input  1  watchdog refresh enable, shared by all channels.
REQ-009 SHALL provide port i_wdgintb_config  input  2  index into the WDG_INTB_TH table.
REQ-010 SHALL provide port o_hv_pwm_intb_n  output  CH_NUM  per-channel PWM wave with INTB symbols inserted.
REQ-011 SHALL provide port o_busy  output  CH_NUM  channel is transmitting a symbol.
REQ-012 SHALL provide port o_drop  output  CH_NUM  one-cycle pulse when a pending event is overwritten.

Function
REQ-013 SHALL register i_hv_intb_n per channel: a rising edge is an INTB1 event and a falling edge is an INTB0 event.
REQ-014 Per-channel FSM states SHALL be IDLE, B1_0, B1_1, B1_2 and B0; each non-IDLE state lasts exactly EXT_CYC_NUM cycles.
REQ-015 On an INTB1 event: IDLE->B1_0->B1_1->B1_2->IDLE. On an INTB0 event: IDLE->B0->IDLE.
REQ-016 SHALL latch gwave_lock = i_hv_pwm_gwave in the cycle a symbol starts.
REQ-017 Bit values SHALL be: B1_0 = ~lock, B1_1 = lock, B1_2 = ~lock, B0 = ~lock.
REQ-018 Output SHALL be registered: o_hv_pwm_intb_n = bit value when non-IDLE, else i_hv_pwm_gwave; latency 1 cycle from the event or input change.
REQ-019 o_busy SHALL be high exactly while the FSM is non-IDLE, registered with the same alignment as the output.
REQ-020 SHALL hold a one-entry pending slot (valid + type) per channel; an event arriving while non-IDLE is stored in the slot.
REQ-021 An event arriving while the slot is already full SHALL overwrite the slot with the newest event and pulse o_drop for 1 cycle.
REQ-022 On the final cycle of a symbol with the slot valid: the next symbol SHALL start the following cycle with no IDLE gap, re-latch gwave_lock, and clear the slot.
REQ-023 Per-channel watchdog counter SHALL count while i_wdgintb_en=1; it clears on any edge, when enable is 0, and after each refresh.
REQ-024 A refresh SHALL fire when cnt >= WDG_INTB_TH[cfg]-1 (>= so that a cfg decrease fires immediately); it issues an INTB1 event if i_hv_intb_n=1, else an INTB0 event.
REQ-025 Refresh SHALL be accepted only in IDLE with the slot empty; otherwise it is discarded and the counter clears.
REQ-026 A simultaneous edge and refresh SHALL be treated as the edge only.
REQ-027 Deasserting i_wdgintb_en mid-symbol SHALL let the symbol complete.

Reset
REQ-028 While i_rst=1 on a clock edge: FSMs go to IDLE, slots and counters clear, intb_n registers go to 1, lock goes to 0, o_hv_pwm_intb_n = 0, o_busy = 0, o_drop = 0.
REQ-029 A reset mid-symbol SHALL abort the symbol; no event is generated by the intb_n register reloading to 1.

Configuration
REQ-030 Macro HV_PWM_INTB_WDG_EN defined: the watchdog per REQ-023..REQ-027 is present. Undefined: no counters are synthesised, refresh never fires, and i_wdgintb_en and i_wdgintb_config are ignored.

Structure
REQ-031 Package hv_pwm_intb_pkg SHALL hold the FSM state enum typedef, the event type typedef, and WDG_INTB_TH = {64,128,256,512}.
REQ-032 Per-channel logic SHALL be sub-module hv_pwm_intb_enc_ch, instantiated CH_NUM times by a generate loop; the top holds only shared config fan-out.

Verification (CH_NUM=2, EXT_CYC_NUM=4)
REQ-033 ch0 intb_n 0->1, gwave=0 -> output 1,1,1,1,0,0,0,0,1,1,1,1 starting 1 cycle after the edge, then follows gwave; o_busy high for 12 cycles.
REQ-034 ch1 intb_n 1->0, gwave=1 -> output 0 for 4 cycles, then gwave; ch0 output unchanged.
REQ-035 Rise, then fall 3 cycles later -> 12-cycle INTB1 immediately followed by 4-cycle INTB0; o_busy high for 16 contiguous cycles; o_drop stays 0.
REQ-036 Rise, fall, rise within a single symbol -> o_drop pulses once; the final INTB1 is sent after the first symbol; the INTB0 is never sent.
REQ-037 Macro defined, en=1, cfg=0, intb_n held at 1 -> INTB1 symbol every 64 cycles. Macro undefined -> no symbols.
REQ-038 i_rst asserted at the 6th cycle of an INTB1 symbol -> next cycle output 0 and o_busy 0; after release, output follows gwave.

Source files
------------

// File: rtl/hv_pwm_intb_pkg.sv
// Shared types and constants for the multi-channel PWM/INTB symbol encoder.
package hv_pwm_intb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B1_0 = 3'd1,
        ST_B1_1 = 3'd2,
        ST_B1_2 = 3'd3,
        ST_B0   = 3'd4
    } state_t;

    typedef enum logic {
        EV_INTB0 = 1'b0,
        EV_INTB1 = 1'b1
    } evt_t;

    // Watchdog refresh periods in clock cycles, indexed by the 2-bit config.
    localparam logic [3:0][9:0] WDG_INTB_TH = {10'd512, 10'd256, 10'd128, 10'd64};

    // Only the middle INTB1 bit carries the locked gate level; all others invert it.
    function automatic logic sym_bit(state_t st, logic lock);
        return (st == ST_B1_1) ? lock : ~lock;
    endfunction

    function automatic state_t sym_start(evt_t ev);
        return (ev == EV_INTB1) ? ST_B1_0 : ST_B0;
    endfunction

endpackage

// File: rtl/hv_pwm_intb_enc_ch.sv
// One PWM/INTB channel: edge detect, symbol FSM, one-entry pending slot and
// optional refresh watchdog (present when HV_PWM_INTB_WDG_EN is defined).
module hv_pwm_intb_enc_ch
    import hv_pwm_intb_pkg::*;
#(
    parameter int EXT_CYC_NUM = 4,
    parameter int WDG_CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intb_n,
    input  logic       gwave,
    input  logic       wdg_en,
    input  logic [9:0] wdg_th_m1,
    output logic       pwm_intb_n,
    output logic       busy,
    output logic       drop
);

    localparam int CYC_W = $clog2(EXT_CYC_NUM);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(EXT_CYC_NUM - 1);

    state_t           state, state_nxt;
    logic [CYC_W-1:0] cyc, cyc_nxt;
    logic             intb_q;
    logic             lock, lock_nxt;
    logic             slot_vld, slot_vld_nxt;
    evt_t             slot_typ, slot_typ_nxt;
    logic             drop_nxt;
    logic             edge_evt;
    logic             refresh;
    logic             evt;
    evt_t             evt_typ;

    assign edge_evt = intb_n ^ intb_q;
    // Edge type and refresh type both follow the current level, so one source serves both.
    assign evt_typ  = intb_n ? EV_INTB1 : EV_INTB0;
    assign evt      = edge_evt | refresh;

`ifdef HV_PWM_INTB_WDG_EN
    logic [WDG_CNT_W-1:0] wdg_cnt;
    logic                 wdg_fire;

    // >= so a threshold lowered below the running count fires at once.
    assign wdg_fire = wdg_en && (32'(wdg_cnt) >= 32'(wdg_th_m1));
    assign refresh  = wdg_fire && !edge_evt && (state == ST_IDLE) && !slot_vld;

    always_ff @(posedge clk) begin
        if (rst || !wdg_en || edge_evt || wdg_fire) wdg_cnt <= '0;
        else                                        wdg_cnt <= wdg_cnt + 1'b1;
    end
`else
    logic unused_wdg;
    assign unused_wdg = ^{wdg_en, wdg_th_m1};
    assign refresh    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cyc        <= '0;
            intb_q     <= 1'b1;
            lock       <= 1'b0;
            slot_vld   <= 1'b0;
            slot_typ   <= EV_INTB0;
            pwm_intb_n <= 1'b0;
            busy       <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cyc        <= cyc_nxt;
            intb_q     <= intb_n;
            lock       <= lock_nxt;
            slot_vld   <= slot_vld_nxt;
            slot_typ   <= slot_typ_nxt;
            pwm_intb_n <= (state_nxt == ST_IDLE) ? gwave : sym_bit(state_nxt, lock_nxt);
            busy       <= (state_nxt != ST_IDLE);
            drop       <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cyc_nxt      = cyc;
        lock_nxt     = lock;
        slot_vld_nxt = slot_vld;
        slot_typ_nxt = slot_typ;
        drop_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (evt) begin
                    state_nxt = sym_start(evt_typ);
                    cyc_nxt   = '0;
                    lock_nxt  = gwave;
                end
            end
            default: begin
                cyc_nxt = cyc + 1'b1;
                if (evt) begin
                    slot_vld_nxt = 1'b1;
                    slot_typ_nxt = evt_typ;
                    drop_nxt     = slot_vld;
                end
                if (cyc == CYC_LAST) begin
                    cyc_nxt = '0;
                    case (state)
                        ST_B1_0: state_nxt = ST_B1_1;
                        ST_B1_1: state_nxt = ST_B1_2;
                        default: begin
                            // Symbol end: the slot is consumed now, so a same-cycle event refills it without a drop.
                            if (slot_vld) begin
                                state_nxt    = sym_start(slot_typ);
                                lock_nxt     = gwave;
                                slot_vld_nxt = evt;
                                drop_nxt     = 1'b0;
                            end else if (evt) begin
                                state_nxt    = sym_start(evt_typ);
                                lock_nxt     = gwave;
                                slot_vld_nxt = 1'b0;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/hv_pwm_intb_encode_mch.sv
// Multi-channel PWM/INTB encoder top: shared watchdog config fan-out to
// CH_NUM channel instances. Watchdog built only with HV_PWM_INTB_WDG_EN.
module hv_pwm_intb_encode_mch
    import hv_pwm_intb_pkg::*;
#(
    parameter int CH_NUM      = 2,
    parameter int EXT_CYC_NUM = 4,
    parameter int WDG_CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_NUM-1:0] i_hv_intb_n,
    input  logic [CH_NUM-1:0] i_hv_pwm_gwave,
    input  logic              i_wdgintb_en,
    input  logic [1:0]        i_wdgintb_config,
    output logic [CH_NUM-1:0] o_hv_pwm_intb_n,
    output logic [CH_NUM-1:0] o_busy,
    output logic [CH_NUM-1:0] o_drop
);

    logic       wdg_en;
    logic [9:0] wdg_th_m1;

`ifdef HV_PWM_INTB_WDG_EN
    assign wdg_en    = i_wdgintb_en;
    assign wdg_th_m1 = WDG_INTB_TH[i_wdgintb_config] - 10'd1;
`else
    logic unused_cfg;
    assign unused_cfg = ^{i_wdgintb_en, i_wdgintb_config};
    assign wdg_en     = 1'b0;
    assign wdg_th_m1  = '0;
`endif

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        hv_pwm_intb_enc_ch #(
            .EXT_CYC_NUM(EXT_CYC_NUM),
            .WDG_CNT_W  (WDG_CNT_W)
        ) u_ch (
            .clk       (i_clk),
            .rst       (i_rst),
            .intb_n    (i_hv_intb_n[g]),
            .gwave     (i_hv_pwm_gwave[g]),
            .wdg_en    (wdg_en),
            .wdg_th_m1 (wdg_th_m1),
            .pwm_intb_n(o_hv_pwm_intb_n[g]),
            .busy      (o_busy[g]),
            .drop      (o_drop[g])
        );
    end

endmodule

// File: tb/tb_hv_pwm_intb_encode_mch.sv
// Directed bench for hv_pwm_intb_encode_mch (CH_NUM=2, EXT_CYC_NUM=4).
module tb_hv_pwm_intb_encode_mch;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] intb_n;
    logic [1:0] gwave;
    logic       wdg_en;
    logic [1:0] wdg_cfg;
    logic [1:0] pwm_out;
    logic [1:0] busy;
    logic [1:0] drop;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [1:0] intb;
        logic [1:0] gw;
        logic [1:0] out;
        logic [1:0] busy;
        logic [1:0] drop;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    hv_pwm_intb_encode_mch #(
        .CH_NUM     (2),
        .EXT_CYC_NUM(4),
        .WDG_CNT_W  (16)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_hv_intb_n     (intb_n),
        .i_hv_pwm_gwave  (gwave),
        .i_wdgintb_en    (wdg_en),
        .i_wdgintb_config(wdg_cfg),
        .o_hv_pwm_intb_n (pwm_out),
        .o_busy          (busy),
        .o_drop          (drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] ib, input logic [1:0] g,
                       input logic [1:0] o, input logic [1:0] b, input logic [1:0] d);
        vec_t v;
        v.rst = r; v.intb = ib; v.gw = g; v.out = o; v.busy = b; v.drop = d;
        vecs.push_back(v);
    endtask

    initial begin
        logic [11:0] pat;
        logic [15:0] pat16;
        logic [4:0]  pat5;
        int          drops;
        int          busy_cnt;

        rst = 1'b1; intb_n = 2'b11; gwave = 2'b00; wdg_en = 1'b0; wdg_cfg = 2'b00;
        pat = 12'b1111_0000_1111;

        // reset, then idle pass-through
        add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00);
        add(0, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00);
        // ch0 fall with gwave 0 -> INTB0 emits 1
        for (int i = 0; i < 4; i++) add(0, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        // ch0 rise, lock=0; gwave changes mid-symbol must not disturb ch0
        add(0, 2'b11, 2'b00, {1'b0, pat[11]}, 2'b01, 2'b00);
        for (int i = 1; i < 12; i++) add(0, 2'b11, 2'b11, {1'b1, pat[11-i]}, 2'b01, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
        // ch1 fall with gwave 1 -> 0 for 4 cycles, ch0 follows its gwave
        for (int i = 0; i < 4; i++) add(0, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
        // ch1 rise with lock=1 -> inverted INTB1 pattern
        for (int i = 0; i < 12; i++) add(0, 2'b11, 2'b10, {~pat[11-i], 1'b0}, 2'b10, 2'b00);
        add(0, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; intb_n = vecs[i].intb; gwave = vecs[i].gw;
            tick();
            chk($sformatf("vec%0d out", i),  pwm_out, vecs[i].out);
            chk($sformatf("vec%0d busy", i), busy,    vecs[i].busy);
            chk($sformatf("vec%0d drop", i), drop,    vecs[i].drop);
        end

        // back-to-back: rise then fall 3 cycles later -> INTB1 then INTB0, no gap
        intb_n = 2'b10; gwave = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        pat16 = 16'b1111_0000_1111_1111;
        intb_n = 2'b11;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 2) intb_n = 2'b10;
            chk($sformatf("b2b out%0d", i),  {1'b0, pwm_out[0]}, {1'b0, pat16[15-i]});
            chk($sformatf("b2b busy%0d", i), {1'b0, busy[0]},    2'b01);
            chk($sformatf("b2b drop%0d", i), drop,               2'b00);
        end
        tick();
        chk("b2b busy_end", busy, 2'b00);

        // rise, fall, rise in one symbol -> one drop, INTB1 twice, no INTB0
        drops = 0;
        intb_n = 2'b11;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 1) intb_n = 2'b10;
            if (i == 3) intb_n = 2'b11;
            if (drop[0]) drops++;
            chk($sformatf("ovr out%0d", i),  {1'b0, pwm_out[0]}, {1'b0, pat[11-(i%12)]});
            chk($sformatf("ovr busy%0d", i), {1'b0, busy[0]},    2'b01);
            if (i == 4) chk("ovr drop_pulse", drop, 2'b01);
        end
        tick();
        chk("ovr busy_end", busy, 2'b00);
        chk_int("ovr drop_count", drops, 1);

        // watchdog refresh with intb_n held high
        intb_n = 2'b11; gwave = 2'b00; wdg_en = 1'b1; wdg_cfg = 2'b00;
`ifdef HV_PWM_INTB_WDG_EN
        begin
            int   starts[$];
            logic prev;
            logic [1:0] first_busy;
            prev = 1'b0;
            first_busy = 2'b00;
            for (int c = 0; c < 200; c++) begin
                tick();
                if (busy[0] && !prev) begin
                    if (starts.size() == 0) first_busy = busy;
                    starts.push_back(c);
                end
                prev = busy[0];
            end
            chk_int("wdg starts", starts.size(), 3);
            if (starts.size() >= 3) begin
                chk_int("wdg period1", starts[1] - starts[0], 64);
                chk_int("wdg period2", starts[2] - starts[1], 64);
            end
            chk("wdg both_ch", first_busy, 2'b11);
        end
`else
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (busy != 2'b00) busy_cnt++;
        end
        chk_int("wdg disabled_busy", busy_cnt, 0);
`endif
        wdg_en = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("wdg drained", busy, 2'b00);

        // reset at the 6th cycle of an INTB1 symbol
        intb_n = 2'b10; gwave = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        pat5 = 5'b11110;
        intb_n = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rst_mid out%0d", i), {1'b0, pwm_out[0]}, {1'b0, pat5[4-i]});
        end
        rst = 1'b1;
        tick();
        chk("rst_mid out", pwm_out, 2'b00);
        chk("rst_mid busy", busy, 2'b00);
        rst = 1'b0; gwave = 2'b01;
        tick();
        chk("post_rst out", pwm_out, 2'b01);
        chk("post_rst busy", busy, 2'b00);
        gwave = 2'b10;
        tick();
        chk("post_rst out2", pwm_out, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
